// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding a one-entry commit stage for the register file write port.
// Optional macro WB_BYPASS_EN: forward commit-stage data on hits instead of stalling the issue stage.
module regfile_wb_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          fwd1_valid,
    output logic [DW-1:0] fwd1_data,
    output logic          fwd2_valid,
    output logic [DW-1:0] fwd2_data,
    output logic          stall,
    output logic [CW-1:0] conflict_cnt
);

    logic          rr_last_q, rr_last_d;
    logic          st_valid_q, st_valid_d;
    logic [AW-1:0] st_addr_q, st_addr_d;
    logic [DW-1:0] st_data_q, st_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0, gnt1;
    logic [AW-1:0] rd_addr [2];
    logic [1:0]    hit;

    // rr_last_q = 1 means requester 1 won the last transfer, so requester 0 wins the next contest.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                gnt0 = rr_last_q;
                gnt1 = !rr_last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    always_comb begin
        rr_last_d  = rr_last_q;
        st_valid_d = 1'b0;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        cnt_d      = cnt_q;
        if (gnt0) begin
            rr_last_d  = 1'b0;
            st_valid_d = 1'b1;
            st_addr_d  = req0_addr;
            st_data_d  = req0_data;
        end else if (gnt1) begin
            rr_last_d  = 1'b1;
            st_valid_d = 1'b1;
            st_addr_d  = req1_addr;
            st_data_d  = req1_data;
        end
        if (req0_valid && req1_valid && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q  <= 1'b1;
            st_valid_q <= 1'b0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            st_valid_q <= st_valid_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign rf_we        = st_valid_q && (st_addr_q != '0);
    assign rf_wa        = st_addr_q;
    assign rf_wd        = st_data_q;
    assign conflict_cnt = cnt_q;

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    // Register 0 is hardwired, so reading it never needs the in-flight value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hit
            assign hit[gi] = st_valid_q && (st_addr_q == rd_addr[gi]) && (rd_addr[gi] != '0);
        end
    endgenerate

`ifdef WB_BYPASS_EN
    assign fwd1_valid = hit[0];
    assign fwd2_valid = hit[1];
    assign fwd1_data  = st_data_q;
    assign fwd2_data  = st_data_q;
    assign stall      = 1'b0;
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
    assign stall      = |hit;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: directed scenarios plus a per-cycle behavioural model check.
module tb_regfile_wb_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic          fwd1_valid, fwd2_valid;
    logic [DW-1:0] fwd1_data, fwd2_data;
    logic          stall;
    logic [CW-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
        .stall(stall), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: who won last, what write is in flight this cycle, and the contention count.
    logic          started = 1'b0;
    logic          m_last  = 1'b1;
    logic          m_st_v  = 1'b0;
    logic [AW-1:0] m_st_a  = '0;
    logic [DW-1:0] m_st_d  = '0;
    logic [CW-1:0] m_cnt   = '0;

    always @(posedge clk) if (!rst_n) started <= 1'b1;

    task automatic model_step();
        logic w0, w1, h1, h2, e_we;
        if (!started) return;
        if (!rst_n) begin
            w0 = 1'b0; w1 = 1'b0;
        end else if (req0_valid && req1_valid) begin
            w0 = m_last; w1 = !m_last;
        end else begin
            w0 = req0_valid; w1 = req1_valid;
        end
        chk("m_ready0", req0_ready, w0);
        chk("m_ready1", req1_ready, w1);
        e_we = m_st_v && (m_st_a != 0);
        chk("m_rf_we", rf_we, e_we);
        if (e_we) begin
            chk("m_rf_wa", rf_wa, m_st_a);
            chk("m_rf_wd", rf_wd, m_st_d);
        end
        h1 = m_st_v && (m_st_a == rd_addr1) && (rd_addr1 != 0);
        h2 = m_st_v && (m_st_a == rd_addr2) && (rd_addr2 != 0);
`ifdef WB_BYPASS_EN
        chk("m_fwd1_valid", fwd1_valid, h1);
        chk("m_fwd2_valid", fwd2_valid, h2);
        if (m_st_v) begin
            chk("m_fwd1_data", fwd1_data, m_st_d);
            chk("m_fwd2_data", fwd2_data, m_st_d);
        end
        chk("m_stall", stall, 1'b0);
`else
        chk("m_fwd1_valid", fwd1_valid, 1'b0);
        chk("m_fwd2_valid", fwd2_valid, 1'b0);
        chk("m_fwd1_data", fwd1_data, 0);
        chk("m_fwd2_data", fwd2_data, 0);
        chk("m_stall", stall, h1 | h2);
`endif
        chk("m_conflict_cnt", conflict_cnt, m_cnt);
        $display("cyc rst_n=%0b v=%0b%0b rdy=%0b%0b we=%0b wa=%0d wd=%h stall=%0b cnt=%0d",
                 rst_n, req0_valid, req1_valid, req0_ready, req1_ready, rf_we, rf_wa, rf_wd,
                 stall, conflict_cnt);
        if (!rst_n) begin
            m_last = 1'b1; m_st_v = 1'b0; m_cnt = '0;
        end else begin
            if (w0) begin
                m_st_v = 1'b1; m_st_a = req0_addr; m_st_d = req0_data; m_last = 1'b0;
            end else if (w1) begin
                m_st_v = 1'b1; m_st_a = req1_addr; m_st_d = req1_data; m_last = 1'b1;
            end else begin
                m_st_v = 1'b0;
            end
            if (req0_valid && req1_valid && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
        end
    endtask

    always @(negedge clk) model_step();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic g0, g1;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 32'hA0A0_0001;
        req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 32'hB0B0_0002;
        rd_addr1 = '0; rd_addr2 = '0;

        // Reset held two cycles with both requesters valid.
        tick(); #2;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_wa", rf_wa, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_cnt", conflict_cnt, 0);
        tick();
        rst_n = 1'b1;
        #2;
        chk("rst_first_grant0", req0_ready, 1'b1);
        chk("rst_first_grant1", req1_ready, 1'b0);

        // Contention: grants alternate 0,1,0,1; writes land in the same order.
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                #2;
                chk("cont_ready0", req0_ready, (k % 2) == 0);
                chk("cont_ready1", req1_ready, (k % 2) == 1);
                chk("cont_rf_wa", rf_wa, ((k - 1) % 2 == 0) ? 1 : 2);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2;
        chk("cont_last_wa", rf_wa, 2);
        chk("cont_cnt", conflict_cnt, 4);

        // Single write.
        tick();
        req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 32'hDEADBEEF;
        #2 chk("single_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #2;
        chk("single_we", rf_we, 1'b1);
        chk("single_wa", rf_wa, 5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);
        tick();
        #2 chk("single_we_drop", rf_we, 1'b0);

        // Register 0 write: handshake completes but nothing is written, and no hazard.
        tick();
        req1_valid = 1'b1; req1_addr = 6'd0; req1_data = 32'hFFFFFFFF; rd_addr1 = 6'd0;
        #2 chk("r0_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        #2;
        chk("r0_ready1_once", req1_ready, 1'b0);
        chk("r0_we", rf_we, 1'b0);
        chk("r0_stall", stall, 1'b0);
        chk("r0_fwd1", fwd1_valid, 1'b0);

        // Hazard on read port 1 in the cycle after acceptance only.
        tick();
        req0_valid = 1'b1; req0_addr = 6'd9; req0_data = 32'h12345678;
        rd_addr1 = 6'd9; rd_addr2 = 6'd3;
        tick();
        req0_valid = 1'b0;
        #2;
`ifdef WB_BYPASS_EN
        chk("haz_fwd1_valid", fwd1_valid, 1'b1);
        chk("haz_fwd1_data", fwd1_data, 32'h12345678);
        chk("haz_stall", stall, 1'b0);
`else
        chk("haz_stall", stall, 1'b1);
        chk("haz_fwd1_valid", fwd1_valid, 1'b0);
`endif
        tick();
        #2;
        chk("haz_stall_after", stall, 1'b0);
        chk("haz_fwd1_after", fwd1_valid, 1'b0);

        // Saturation: 20 contested cycles pin the 4-bit counter at 15.
        tick();
        req0_valid = 1'b1; req0_addr = 6'd11; req0_data = 32'h1111_1111;
        req1_valid = 1'b1; req1_addr = 6'd12; req1_data = 32'h2222_2222;
        repeat (20) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2 chk("sat_cnt", conflict_cnt, 15);
        tick();

        // Random phase: requesters hold until granted, occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 199) != 0);
            if (!req0_valid || g0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                req0_data  = $urandom;
            end
            if (!req1_valid || g1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                req1_data  = $urandom;
            end
            rd_addr1 = AW'($urandom_range(0, 7));
            rd_addr2 = AW'($urandom_range(0, 7));
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
